cond_code_unit: RTL

COND_CODE_UNIT -- requirements
Module: cond_code_unit

---
 rtl/cond_code_unit_if.sv | 23 ++
 rtl/cond_code_unit.sv | 85 ++++++++
 2 files changed

// File: rtl/cond_code_unit_if.sv
// Controller-side bundle for the condition code unit: flag strobe, decode fields,
// ALU flags in; registered condition/PSR word and carry out.
interface cond_code_unit_if #(
    parameter int WIDTH = 16
);
    logic             codesComputed;
    logic [3:0]       opCode;
    logic [3:0]       opCodeExt;
    logic [3:0]       cond;
    logic [4:0]       aluFlags;
    logic [WIDTH-1:0] conCodesOut;
    logic             carryIn;

    modport master (
        output codesComputed, opCode, opCodeExt, cond, aluFlags,
        input  conCodesOut, carryIn
    );

    modport slave (
        input  codesComputed, opCode, opCodeExt, cond, aluFlags,
        output conCodesOut, carryIn
    );
endinterface

// File: rtl/cond_code_unit.sv
// Condition code unit: holds the PSR {N,Z,F,L,C} and registers cond evaluation.
// Optional macro FLAG_BYPASS_EN evaluates against the PSR being written this cycle.
module cond_code_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    cond_code_unit_if.slave  bus
);
    // PSR bit positions
    localparam int F_N = 4;
    localparam int F_Z = 3;
    localparam int F_F = 2;
    localparam int F_L = 1;
    localparam int F_C = 0;

    localparam logic [4:0] CMP_MASK = 5'b11010;  // N, Z, L
    localparam logic [4:0] ARI_MASK = 5'b00101;  // F, C

    logic [4:0]       psr_q, psr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             is_cmp;
    logic [4:0]       upd_mask;
    logic [4:0]       eval_psr;

    function automatic logic eval(input logic [4:0] f, input logic [3:0] c);
        logic n, z, fl, l, cy;
        n  = f[F_N];
        z  = f[F_Z];
        fl = f[F_F];
        l  = f[F_L];
        cy = f[F_C];
        case (c)
            4'b0000: eval = z;
            4'b0001: eval = !z;
            4'b0010: eval = cy;
            4'b0011: eval = !cy;
            4'b0100: eval = l;
            4'b0101: eval = !l;
            4'b0110: eval = n;
            4'b0111: eval = !n;
            4'b1000: eval = fl;
            4'b1001: eval = !fl;
            4'b1010: eval = !l && !z;
            4'b1011: eval = l || z;
            4'b1100: eval = !n && !z;
            4'b1101: eval = n || z;
            4'b1110: eval = 1'b1;
            default: eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        is_cmp   = (bus.opCode == 4'b0000 && bus.opCodeExt == 4'b1011) || bus.opCode == 4'b1011;
        upd_mask = is_cmp ? CMP_MASK : ARI_MASK;
        psr_d    = psr_q;
        if (bus.codesComputed)
            psr_d = (psr_q & ~upd_mask) | (bus.aluFlags & upd_mask);
    end

`ifdef FLAG_BYPASS_EN
    assign eval_psr = psr_d;
`else
    assign eval_psr = psr_q;
`endif

    always_comb begin
        out_d      = '0;
        out_d[5:1] = eval_psr;
        out_d[0]   = eval(eval_psr, bus.cond);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psr_q <= '0;
            out_q <= '0;
        end else begin
            psr_q <= psr_d;
            out_q <= out_d;
        end
    end

    assign bus.conCodesOut = out_q;
    assign bus.carryIn     = psr_q[F_C];
endmodule
